nv_ram_rws_16x64_fifo_ctrl: RTL and testbench
=============================================

# nv_ram_rws_16x64_fifo_ctrl

Valid/ready FIFO controller that sequences an external 16-entry x 64-bit separate-read/write-port RAM (registered read address, one-cycle read latency). It owns write/read pointers, occupancy and the read-issue pipeline, and turns the raw RAM ports into a flow-controlled push/pop interface. Instantiated beside the RAM inside NVDLA core-clock-domain buffering paths.

## Interface
- No parameters; geometry fixed at depth 16, width 64, pointer width 4, count width 5.
- nvdla_core_clk  in  1  core clock; all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- wr_pvld  in  1  push request.
- wr_prdy  out  1  push accept; registered.
- wr_pd  in  64  push data.
- rd_pvld  out  1  pop data valid; registered.
- rd_prdy  in  1  pop accept.
- rd_pd  out  64  pop data (= ram_dout).
- ram_we  out  1  RAM write enable.
- ram_wa  out  4  RAM write address.
- ram_di  out  64  RAM write data (= wr_pd).
- ram_re  out  1  RAM read-address capture enable.
- ram_ra  out  4  RAM read address.
- ram_dout  in  64  RAM read data, valid the cycle after ram_re.
- occupancy  out  5  entries pushed and not yet popped (0..16); registered.

## Operation
- State: wr_adr[3:0], rd_adr[3:0], occ[4:0], avail[4:0] (pushed, not yet read-issued), rd_pvld, wr_prdy.
- push = wr_pvld & wr_prdy. ram_we = push, ram_wa = wr_adr; wr_adr += 1 mod 16 on push.
- pop = rd_pvld & rd_prdy.
- issue = (avail != 0) & (!rd_pvld | rd_prdy). ram_re = issue, ram_ra = rd_adr; rd_adr += 1 mod 16 on issue.
- rd_pvld next = issue ? 1 : (pop ? 0 : rd_pvld).
- avail next = avail + push - issue; occ next = occ + push - pop (push and same-cycle decrement leave count unchanged).
- wr_prdy next = (occ_next != 16). A pop in the same cycle occ==16 does not allow a push that cycle; wr_prdy rises the following cycle.
- rd_pd is ram_dout directly; presented entry is never overwritten because its slot is counted in occ until popped, so rd_pd holds stable while rd_pvld & !rd_prdy.
- Pointer wrap 15->0 is natural 4-bit overflow; full/empty distinguished by occ, never by pointer compare.
- Ordering strictly FIFO; no drop, no duplication.

## Timing
- Reset values: wr_prdy=0, rd_pvld=0, occupancy=0, ram_we=0, ram_re=0, ram_wa=0, ram_ra=0, all pointers/counters 0. wr_prdy rises on first clock edge after rstn deasserts.
- Push-to-valid latency: push in cycle N -> RAM written at end of N, avail visible N+1, issue N+1, rd_pvld=1 with data in N+2.
- Throughput: 1 push and 1 pop per cycle sustained; with rd_prdy held 1 and avail>0, issue fires every cycle and rd_pvld stays high.
- Empty: avail==0 -> no ram_re; rd_pvld falls the cycle after final pop.
- Full: occ==16 -> wr_prdy=0; ram_we never asserts.
- Reset asserted mid-operation: all state cleared immediately (async), in-flight and stored entries discarded, ram_we/ram_re deassert immediately; RAM contents left stale and never presented.

## Test plan
- Reset: hold rstn=0 with wr_pvld=1 -> wr_prdy=0, rd_pvld=0, ram_we=0, ram_re=0, occupancy=0; wr_prdy=1 one cycle after release.
- Single entry: push 0x0123_4567_89AB_CDEF in cycle 0, rd_prdy=1 -> ram_we cycle 0 at wa=0, ram_re cycle 1 at ra=0, rd_pvld=1 with that data cycle 2, occupancy 1 -> 0 after pop.
- Fill: rd_prdy=0, push 0x0..0xF -> wr_prdy=0 cycle after 16th push, occupancy=16, rd_pd=0x0 held stable; one pop -> wr_prdy=1 next cycle, occupancy=15.
- Streaming wrap: push 40 incrementing words every cycle, rd_prdy=1 -> output 0..39 in order, one per cycle after 2-cycle fill, pointers wrap twice, occupancy never exceeds 3.
- Random backpressure: random wr_pvld/rd_prdy over 1000 words -> scoreboard exact order, rd_pd unchanged while rd_pvld & !rd_prdy, ram_we never when occupancy=16.
- Mid-operation reset: 5 entries stored, assert rstn=0 one cycle -> occupancy=0, rd_pvld=0; next pushed word 0xAA..AA is first word popped.

Source files
------------

// File: rtl/nv_ram_rws_16x64_fifo_ctrl.sv
// Valid/ready FIFO controller for an external 16x64 RAM with a registered read address.
// Holds the pointers, the occupancy and the read-issue pipeline that turn raw RAM ports into push/pop.
module nv_ram_rws_16x64_fifo_ctrl (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [63:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [63:0] rd_pd,
    output logic        ram_we,
    output logic [3:0]  ram_wa,
    output logic [63:0] ram_di,
    output logic        ram_re,
    output logic [3:0]  ram_ra,
    input  logic [63:0] ram_dout,
    output logic [4:0]  occupancy
);

    logic [3:0] wr_adr_reg, wr_adr_next;
    logic [3:0] rd_adr_reg, rd_adr_next;
    logic [4:0] occ_reg, occ_next;
    logic [4:0] avail_reg, avail_next;
    logic       rd_pvld_reg, rd_pvld_next;
    logic       wr_prdy_reg, wr_prdy_next;
    logic       push, pop, issue;

    always_comb begin
        push  = wr_pvld & wr_prdy_reg;
        pop   = rd_pvld_reg & rd_prdy;
        // A read is issued only when the output stage is free or being drained this cycle.
        issue = (avail_reg != 5'd0) & (~rd_pvld_reg | rd_prdy);

        wr_adr_next  = wr_adr_reg + {3'd0, push};
        rd_adr_next  = rd_adr_reg + {3'd0, issue};
        avail_next   = avail_reg + {4'd0, push} - {4'd0, issue};
        occ_next     = occ_reg + {4'd0, push} - {4'd0, pop};
        wr_prdy_next = (occ_next != 5'd16);

        rd_pvld_next = rd_pvld_reg;
        if (issue) begin
            rd_pvld_next = 1'b1;
        end else if (pop) begin
            rd_pvld_next = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_adr_reg  <= 4'd0;
            rd_adr_reg  <= 4'd0;
            occ_reg     <= 5'd0;
            avail_reg   <= 5'd0;
            rd_pvld_reg <= 1'b0;
            wr_prdy_reg <= 1'b0;
        end else begin
            wr_adr_reg  <= wr_adr_next;
            rd_adr_reg  <= rd_adr_next;
            occ_reg     <= occ_next;
            avail_reg   <= avail_next;
            rd_pvld_reg <= rd_pvld_next;
            wr_prdy_reg <= wr_prdy_next;
        end
    end

    // The presented slot stays counted in occ until popped, so ram_dout cannot change under it.
    assign rd_pd     = ram_dout;
    assign rd_pvld   = rd_pvld_reg;
    assign wr_prdy   = wr_prdy_reg;
    assign ram_we    = push;
    assign ram_wa    = wr_adr_reg;
    assign ram_di    = wr_pd;
    assign ram_re    = issue;
    assign ram_ra    = rd_adr_reg;
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_nv_ram_rws_16x64_fifo_ctrl.sv
// Directed and randomised checks of the FIFO controller against a behavioural 16x64 RAM.
module tb_nv_ram_rws_16x64_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [63:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [63:0] rd_pd;
    logic        ram_we;
    logic [3:0]  ram_wa;
    logic [63:0] ram_di;
    logic        ram_re;
    logic [3:0]  ram_ra;
    logic [63:0] ram_dout;
    logic [4:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    nv_ram_rws_16x64_fifo_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_we         (ram_we),
        .ram_wa         (ram_wa),
        .ram_di         (ram_di),
        .ram_re         (ram_re),
        .ram_ra         (ram_ra),
        .ram_dout       (ram_dout),
        .occupancy      (occupancy)
    );

    // External RAM: registered read address, contents never reset.
    logic [63:0] mem [16];
    logic [3:0]  ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_pvld = 1'b1;
        wr_pd   = 64'h5555_5555_5555_5555;
        rd_prdy = 1'b0;
        step(); step(); step();
        #1;
        n_checks++;
        if ({wr_prdy, rd_pvld, ram_we, ram_re} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000", {wr_prdy, rd_pvld, ram_we, ram_re});
        end
        n_checks++;
        if (occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_occ: got %0d required 0", occupancy);
        end
        n_checks++;
        if ({ram_wa, ram_ra} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_addr: got %h required 00", {ram_wa, ram_ra});
        end
        wr_pvld = 1'b0;
        rst_n   = 1'b1;
        #1;
        n_checks++;
        if (wr_prdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_prdy: got %b required 0", wr_prdy);
        end
        step();
        n_checks++;
        if (wr_prdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prdy_rise: got %b required 1", wr_prdy);
        end
        $display("reset: released, wr_prdy=%b", wr_prdy);
    endtask

    task automatic test_single();
        logic [63:0] d;
        d       = 64'h0123_4567_89AB_CDEF;
        wr_pvld = 1'b1;
        wr_pd   = d;
        rd_prdy = 1'b1;
        #1;
        n_checks++;
        if ({ram_we, ram_wa} !== 5'b1_0000 || ram_di !== d) begin
            n_fail++;
            $display("FAIL single_write: got we=%b wa=%0d di=%h required we=1 wa=0 di=%h", ram_we, ram_wa, ram_di, d);
        end
        step();
        wr_pvld = 1'b0;
        #1;
        n_checks++;
        if ({ram_re, ram_ra, rd_pvld} !== 6'b1_0000_0 || occupancy !== 5'd1) begin
            n_fail++;
            $display("FAIL single_issue: got re=%b ra=%0d pvld=%b occ=%0d required re=1 ra=0 pvld=0 occ=1", ram_re, ram_ra, rd_pvld, occupancy);
        end
        step();
        #1;
        n_checks++;
        if (rd_pvld !== 1'b1 || rd_pd !== d || occupancy !== 5'd1) begin
            n_fail++;
            $display("FAIL single_data: got pvld=%b pd=%h occ=%0d required pvld=1 pd=%h occ=1", rd_pvld, rd_pd, occupancy, d);
        end
        $display("single: pop data=%h", rd_pd);
        step();
        #1;
        n_checks++;
        if (rd_pvld !== 1'b0 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL single_empty: got pvld=%b occ=%0d required pvld=0 occ=0", rd_pvld, occupancy);
        end
    endtask

    task automatic test_fill();
        int exp_v;
        rd_prdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'(i);
            #1;
            n_checks++;
            if (wr_prdy !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_prdy[%0d]: got %b required 1", i, wr_prdy);
            end
            $display("fill: push data=%h", wr_pd);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'hDEAD_BEEF_0000_0000;
            #1;
            n_checks++;
            if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || occupancy !== 5'd16) begin
                n_fail++;
                $display("FAIL fill_full: got prdy=%b we=%b occ=%0d required prdy=0 we=0 occ=16", wr_prdy, ram_we, occupancy);
            end
            n_checks++;
            if (rd_pvld !== 1'b1 || rd_pd !== 64'h0) begin
                n_fail++;
                $display("FAIL fill_hold: got pvld=%b pd=%h required pvld=1 pd=0", rd_pvld, rd_pd);
            end
            step();
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        #1;
        $display("fill: pop data=%h", rd_pd);
        step();
        rd_prdy = 1'b0;
        #1;
        n_checks++;
        if (wr_prdy !== 1'b1 || occupancy !== 5'd15) begin
            n_fail++;
            $display("FAIL fill_after_pop: got prdy=%b occ=%0d required prdy=1 occ=15", wr_prdy, occupancy);
        end
        rd_prdy = 1'b1;
        exp_v   = 1;
        for (int c = 0; c < 40 && exp_v < 16; c++) begin
            #1;
            if (rd_pvld) begin
                n_checks++;
                if (rd_pd !== 64'(exp_v)) begin
                    n_fail++;
                    $display("FAIL fill_drain: got %h required %h", rd_pd, 64'(exp_v));
                end
                $display("fill: pop data=%h", rd_pd);
                exp_v++;
            end
            step();
        end
        #1;
        n_checks++;
        if (exp_v != 16 || rd_pvld !== 1'b0 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL fill_drained: got popped=%0d pvld=%b occ=%0d required popped=16 pvld=0 occ=0", exp_v, rd_pvld, occupancy);
        end
    endtask

    task automatic test_stream();
        int sent;
        int got;
        sent = 0;
        got  = 0;
        rd_prdy = 1'b1;
        for (int c = 0; c < 60 && got < 40; c++) begin
            wr_pvld = (sent < 40);
            wr_pd   = 64'h1000 + 64'(sent);
            #1;
            if (wr_pvld) begin
                n_checks++;
                if (wr_prdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_prdy: got %b required 1", wr_prdy);
                end
                if (wr_prdy) sent++;
            end
            if (got > 0) begin
                n_checks++;
                if (rd_pvld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_gap: got pvld=%b required 1 after %0d words", rd_pvld, got);
                end
            end
            if (rd_pvld) begin
                n_checks++;
                if (rd_pd !== 64'h1000 + 64'(got)) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h required %h", rd_pd, 64'h1000 + 64'(got));
                end
                $display("stream: pop data=%h", rd_pd);
                got++;
            end
            if (occupancy > 5'd3) begin
                n_fail++;
                $display("FAIL stream_occ: got %0d required <=3", occupancy);
            end
            step();
        end
        wr_pvld = 1'b0;
        n_checks++;
        if (got != 40) begin
            n_fail++;
            $display("FAIL stream_count: got %0d required 40", got);
        end
    endtask

    task automatic test_random();
        logic [63:0] sb[$];
        logic [63:0] prev_pd;
        logic        prev_stall;
        int          pushed;
        int          popped;
        pushed     = 0;
        popped     = 0;
        prev_stall = 1'b0;
        prev_pd    = '0;
        for (int c = 0; c < 10000 && popped < 1000; c++) begin
            wr_pvld = (pushed < 1000) && ($urandom_range(0, 3) != 0);
            wr_pd   = {$urandom, $urandom};
            rd_prdy = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin
                    n_fail++;
                    $display("FAIL random_stable: got pvld=%b pd=%h required pvld=1 pd=%h", rd_pvld, rd_pd, prev_pd);
                end
            end
            if (occupancy == 5'd16) begin
                n_checks++;
                if (ram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_full_we: got we=%b required 0", ram_we);
                end
            end
            if (wr_pvld && wr_prdy) begin
                sb.push_back(wr_pd);
                pushed++;
            end
            if (rd_pvld && rd_prdy) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_extra: got %h required nothing", rd_pd);
                end else begin
                    if (rd_pd !== sb[0]) begin
                        n_fail++;
                        $display("FAIL random_order: got %h required %h", rd_pd, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                $display("random: pop %0d data=%h", popped, rd_pd);
                popped++;
            end
            prev_stall = rd_pvld & ~rd_prdy;
            prev_pd    = rd_pd;
            step();
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        n_checks++;
        if (popped != 1000 || pushed != 1000) begin
            n_fail++;
            $display("FAIL random_count: got pushed=%0d popped=%0d required 1000/1000", pushed, popped);
        end
    endtask

    task automatic test_midreset();
        logic [63:0] d;
        logic        seen;
        d       = 64'hAAAA_AAAA_AAAA_AAAA;
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 64'h7700 + 64'(i);
            step();
        end
        wr_pvld = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 5'd5 || rd_pvld !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got occ=%0d pvld=%b required occ=5 pvld=1", occupancy, rd_pvld);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 5'd0 || {rd_pvld, wr_prdy, ram_we, ram_re} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_clear: got occ=%0d ctrl=%b required occ=0 ctrl=0000", occupancy, {rd_pvld, wr_prdy, ram_we, ram_re});
        end
        step();
        rst_n = 1'b1;
        step();
        wr_pvld = 1'b1;
        wr_pd   = d;
        rd_prdy = 1'b1;
        #1;
        n_checks++;
        if (wr_prdy !== 1'b1 || ram_wa !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_push: got prdy=%b wa=%0d required prdy=1 wa=0", wr_prdy, ram_wa);
        end
        step();
        wr_pvld = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (rd_pvld) begin
                seen = 1'b1;
                n_checks++;
                if (rd_pd !== d) begin
                    n_fail++;
                    $display("FAIL midreset_first: got %h required %h", rd_pd, d);
                end
                $display("midreset: pop data=%h", rd_pd);
            end
            step();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_timeout: got no rd_pvld required one pop");
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_pvld = 1'b0;
        wr_pd   = '0;
        rd_prdy = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
